// File: rtl/aes_dec_pkg.sv
// Shared types, sizes and the linear inverse-round helpers for the AES-128 decrypt controller.
package aes_dec_pkg;

    localparam int NR       = 10;
    localparam int RK_IDX_W = 4;
    localparam int BLOCK_W  = 128;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Byte n of the block lives at [127-8n -: 8]; state is column-major (row = n%4, col = n/4).
    function automatic logic [BLOCK_W-1:0] inv_shift_rows(input logic [BLOCK_W-1:0] s);
        logic [BLOCK_W-1:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                r[BLOCK_W-1-8*(4*c+row) -: 8] = s[BLOCK_W-1-8*(4*((c-row+4)%4)+row) -: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [BLOCK_W-1:0] inv_mix_columns(input logic [BLOCK_W-1:0] s);
        logic [BLOCK_W-1:0] r;
        logic [7:0] a [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < 4; i++) begin
                a[i]  = s[BLOCK_W-1-8*(4*c+i) -: 8];
                x2    = xtime(a[i]);
                x4    = xtime(x2);
                x8    = xtime(x4);
                m9[i] = x8 ^ a[i];
                mb[i] = x8 ^ x2 ^ a[i];
                md[i] = x8 ^ x4 ^ a[i];
                me[i] = x8 ^ x4 ^ x2;
            end
            r[BLOCK_W-1-8*(4*c+0) -: 8] = me[0] ^ mb[1] ^ md[2] ^ m9[3];
            r[BLOCK_W-1-8*(4*c+1) -: 8] = m9[0] ^ me[1] ^ mb[2] ^ md[3];
            r[BLOCK_W-1-8*(4*c+2) -: 8] = md[0] ^ m9[1] ^ me[2] ^ mb[3];
            r[BLOCK_W-1-8*(4*c+3) -: 8] = mb[0] ^ md[1] ^ m9[2] ^ me[3];
        end
        return r;
    endfunction

endpackage

// File: rtl/aes_dec_round.sv
// Combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey, then
// InvMixColumns unless last_round_i is set.
module aes_dec_round
    import aes_dec_pkg::*;
(
    input  logic [BLOCK_W-1:0] st_i,
    input  logic [BLOCK_W-1:0] rk_i,
    input  logic               last_round_i,
    output logic [BLOCK_W-1:0] st_o
);

    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] inv_sub_byte(input logic [7:0] b);
        return INV_SBOX[2047-8*int'(b) -: 8];
    endfunction

    logic [BLOCK_W-1:0] shifted;
    logic [BLOCK_W-1:0] subbed;
    logic [BLOCK_W-1:0] keyed;

    always_comb begin
        shifted = inv_shift_rows(st_i);
        subbed  = '0;
        for (int i = 0; i < 16; i++) begin
            subbed[BLOCK_W-1-8*i -: 8] = inv_sub_byte(shifted[BLOCK_W-1-8*i -: 8]);
        end
        keyed = subbed ^ rk_i;
        st_o  = last_round_i ? keyed : inv_mix_columns(keyed);
    end

endmodule

// File: rtl/aes_dec_ctrl.sv
// Iterative AES-128 decrypt controller: one inverse round per clock over NR rounds.
// Optional abort input is enabled by defining AES_DEC_ABORT_EN.
module aes_dec_ctrl
    import aes_dec_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
`ifdef AES_DEC_ABORT_EN
    input  logic                abort,
`endif
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [BLOCK_W-1:0]  in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [BLOCK_W-1:0]  out_data,
    output logic [RK_IDX_W-1:0] rk_addr,
    input  logic [BLOCK_W-1:0]  rk_data,
    output logic                busy
);

    state_e              state_q, state_d;
    logic [RK_IDX_W-1:0] rnd_q, rnd_d;
    logic [BLOCK_W-1:0]  st_q, st_d;
    logic                out_valid_q, out_valid_d;
    logic [BLOCK_W-1:0]  round_out;
    logic                last_round;
    logic                abort_w;

`ifdef AES_DEC_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    assign last_round = (rnd_q == '0);

    aes_dec_round u_round (
        .st_i         (st_q),
        .rk_i         (rk_data),
        .last_round_i (last_round),
        .st_o         (round_out)
    );

    always_comb begin
        state_d     = state_q;
        rnd_d       = rnd_q;
        st_d        = st_q;
        out_valid_d = out_valid_q;
        if (abort_w) begin
            state_d     = ST_IDLE;
            rnd_d       = '0;
            st_d        = '0;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        st_d    = in_data ^ rk_data;
                        rnd_d   = RK_IDX_W'(NR - 1);
                        state_d = ST_ROUND;
                    end
                end
                ST_ROUND: begin
                    st_d = round_out;
                    if (!last_round) begin
                        rnd_d = rnd_q - 1'b1;
                    end else begin
                        out_valid_d = 1'b1;
                        state_d     = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_d = 1'b0;
                        state_d     = ST_IDLE;
                    end
                end
                default: begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rnd_q       <= '0;
            st_q        <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rnd_q       <= rnd_d;
            st_q        <= st_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Key index is a pure decode so the key store can answer within the same cycle.
    always_comb begin
        case (state_q)
            ST_IDLE:  rk_addr = RK_IDX_W'(NR);
            ST_ROUND: rk_addr = rnd_q;
            default:  rk_addr = '0;
        endcase
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign busy      = (state_q == ST_ROUND) || (state_q == ST_DONE);
    assign out_valid = out_valid_q;
    assign out_data  = st_q;

endmodule

// File: tb/tb_aes_dec_ctrl.sv
// Directed bench for aes_dec_ctrl using FIPS-197 Appendix B and C.1 vectors.
`timescale 1ns/1ps
module tb_aes_dec_ctrl;

    logic         clk = 1'b0;
    logic         rst;
`ifdef AES_DEC_ABORT_EN
    logic         abort;
`endif
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic [3:0]   rk_addr;
    logic [127:0] rk_data;
    logic         busy;

    logic [127:0] rk_mem [16];

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [127:0] CT_A = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT_A = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_B = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_B = 128'h3243f6a8885a308d313198a2e0370734;

    aes_dec_ctrl dut (
        .clk       (clk),
        .rst       (rst),
`ifdef AES_DEC_ABORT_EN
        .abort     (abort),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .rk_addr   (rk_addr),
        .rk_data   (rk_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always_comb rk_data = rk_mem[rk_addr];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // set 0: key 000102..0f (C.1), set 1: key 2b7e1516.. (App. B), other: junk
    task automatic load_keys(input int set);
        for (int i = 0; i < 16; i++) rk_mem[i] = '0;
        if (set == 0) begin
            rk_mem[0]  = 128'h000102030405060708090a0b0c0d0e0f;
            rk_mem[1]  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
            rk_mem[2]  = 128'hb692cf0b643dbdf1be9bc5006830b3fe;
            rk_mem[3]  = 128'hb6ff744ed2c2c9bf6c590cbf0469bf41;
            rk_mem[4]  = 128'h47f7f7bc95353e03f96c32bcfd058dfd;
            rk_mem[5]  = 128'h3caaa3e8a99f9deb50f3af57adf622aa;
            rk_mem[6]  = 128'h5e390f7df7a69296a7553dc10aa31f6b;
            rk_mem[7]  = 128'h14f9701ae35fe28c440adf4d4ea9c026;
            rk_mem[8]  = 128'h47438735a41c65b9e016baf4aebf7ad2;
            rk_mem[9]  = 128'h549932d1f08557681093ed9cbe2c974e;
            rk_mem[10] = 128'h13111d7fe3944a17f307a78b4d2b30c5;
        end else if (set == 1) begin
            rk_mem[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
            rk_mem[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
            rk_mem[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
            rk_mem[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
            rk_mem[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
            rk_mem[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
            rk_mem[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
            rk_mem[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
            rk_mem[8]  = 128'head27321b58dbad2312bf5607f8d292f;
            rk_mem[9]  = 128'hac7766f319fadc2128d12941575c006e;
            rk_mem[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        end else begin
            for (int i = 0; i < 16; i++) rk_mem[i] = {4{32'hdeadbeef}} ^ 128'(i);
        end
    endtask

    // Accept one block from IDLE and follow it to the first cycle out_valid is visible.
    task automatic run_block(input logic [127:0] ct, input logic [127:0] pt, input string tag);
        in_data  = ct;
        in_valid = 1'b1;
        n_tests++;
        if (in_ready !== 1'b1 || rk_addr !== 4'd10) begin
            n_fail++;
            $display("FAIL %s_accept: in_ready=%b rk_addr=%0d, required 1 and 10", tag, in_ready, rk_addr);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int j = 0; j < 10; j++) begin
            n_tests++;
            if (rk_addr !== 4'(9 - j) || out_valid !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL %s_round%0d: rk_addr=%0d out_valid=%b busy=%b in_ready=%b, required %0d 0 1 0",
                         tag, 9 - j, rk_addr, out_valid, busy, in_ready, 9 - j);
            end
            @(posedge clk); #1;
        end
        n_tests++;
        if (out_valid !== 1'b1 || out_data !== pt || rk_addr !== 4'd0) begin
            n_fail++;
            $display("FAIL %s_result: out_valid=%b out_data=%h rk_addr=%0d, required 1 %h 0",
                     tag, out_valid, out_data, rk_addr, pt);
        end
    endtask

    task automatic release_output(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_handshake: out_valid=%b in_ready=%b busy=%b, required 0 1 0",
                     tag, out_valid, in_ready, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 128'h0 || rk_addr !== 4'd10 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b out_data=%h rk_addr=%0d busy=%b, required 1 0 0 10 0",
                     in_ready, out_valid, out_data, rk_addr, busy);
        end
    endtask

    task automatic test_fips_c1();
        load_keys(0);
        run_block(CT_A, PT_A, "c1");
        release_output("c1");
    endtask

    task automatic test_output_stall();
        load_keys(0);
        run_block(CT_A, PT_A, "stall");
        in_valid = 1'b1;
        in_data  = CT_B;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            n_tests++;
            if (out_valid !== 1'b1 || out_data !== PT_A || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_hold%0d: out_valid=%b out_data=%h in_ready=%b, required 1 %h 0",
                         k, out_valid, out_data, in_ready, PT_A);
            end
        end
        in_valid = 1'b0;
        release_output("stall");
    endtask

    task automatic test_back_to_back();
        load_keys(0);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        in_data   = CT_A;
        @(posedge clk); #1;
        in_data = CT_B;
        repeat (10) @(posedge clk);
        #1;
        n_tests++;
        if (out_valid !== 1'b1 || out_data !== PT_A || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_first: out_valid=%b out_data=%h in_ready=%b, required 1 %h 0",
                     out_valid, out_data, in_ready, PT_A);
        end
        load_keys(1);
        @(posedge clk); #1;
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_gap: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_tests++;
        if (in_ready !== 1'b0 || busy !== 1'b1 || rk_addr !== 4'd9) begin
            n_fail++;
            $display("FAIL b2b_second_accept: in_ready=%b busy=%b rk_addr=%0d, required 0 1 9",
                     in_ready, busy, rk_addr);
        end
        repeat (10) @(posedge clk);
        #1;
        n_tests++;
        if (out_valid !== 1'b1 || out_data !== PT_B) begin
            n_fail++;
            $display("FAIL b2b_second: out_valid=%b out_data=%h, required 1 %h", out_valid, out_data, PT_B);
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_end: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_key_swap();
        load_keys(1);
        run_block(CT_B, PT_B, "swapB");
        load_keys(7);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            n_tests++;
            if (out_data !== PT_B || out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL swap_done_stable%0d: out_data=%h out_valid=%b, required %h 1",
                         k, out_data, out_valid, PT_B);
            end
        end
        release_output("swapB");
        load_keys(0);
        run_block(CT_A, PT_A, "swapA");
        release_output("swapA");
    endtask

    task automatic test_reset_mid();
        load_keys(0);
        in_data  = CT_A;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 128'h0 || rk_addr !== 4'd10 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_state: in_ready=%b out_valid=%b out_data=%h rk_addr=%0d busy=%b, required 1 0 0 10 0",
                     in_ready, out_valid, out_data, rk_addr, busy);
        end
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            n_tests++;
            if (out_valid !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_mid_quiet%0d: out_valid=%b busy=%b, required 0 0", k, out_valid, busy);
            end
        end
        run_block(CT_A, PT_A, "rst_after");
        release_output("rst_after");
    endtask

`ifdef AES_DEC_ABORT_EN
    task automatic test_abort();
        load_keys(0);
        in_data  = CT_A;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        n_tests++;
        if (rk_addr !== 4'd4) begin
            n_fail++;
            $display("FAIL abort_round_pos: rk_addr=%0d, required 4", rk_addr);
        end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 128'h0 || rk_addr !== 4'd10 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_round: in_ready=%b out_valid=%b out_data=%h rk_addr=%0d busy=%b, required 1 0 0 10 0",
                     in_ready, out_valid, out_data, rk_addr, busy);
        end
        in_valid = 1'b1;
        abort    = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        abort    = 1'b0;
        n_tests++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || rk_addr !== 4'd10) begin
            n_fail++;
            $display("FAIL abort_idle_accept: in_ready=%b busy=%b rk_addr=%0d, required 1 0 10",
                     in_ready, busy, rk_addr);
        end
        for (int k = 0; k < 11; k++) begin
            @(posedge clk); #1;
            n_tests++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL abort_quiet%0d: out_valid=%b, required 0", k, out_valid);
            end
        end
        run_block(CT_A, PT_A, "abort_done");
        abort     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        abort     = 1'b0;
        out_ready = 1'b0;
        n_tests++;
        if (out_valid !== 1'b0 || out_data !== 128'h0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_done_drop: out_valid=%b out_data=%h in_ready=%b, required 0 0 1",
                     out_valid, out_data, in_ready);
        end
        load_keys(1);
        run_block(CT_B, PT_B, "abort_next");
        release_output("abort_next");
    endtask
`endif

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
`ifdef AES_DEC_ABORT_EN
        abort     = 1'b0;
`endif
        load_keys(0);
        test_reset();
        test_fips_c1();
        test_output_stall();
        test_back_to_back();
        test_key_swap();
        test_reset_mid();
`ifdef AES_DEC_ABORT_EN
        test_abort();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
